aes_sub_bytes_seq: RTL and testbench

- Sequential, parametrised SubBytes / InvSubBytes engine for the AES datapath.
- Accepts a WORD_BYTES-byte state word over a valid/ready handshake and substitutes LANES bytes per cycle through forward or inverse S-box lanes.
- Returns the substituted word over a second valid/ready handshake.
- Sits between AddRoundKey and ShiftRows (encrypt) or InvShiftRows and AddRoundKey (decrypt). It trades area for latency through LANES.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_sbox_lane.sv | 22 ++
 rtl/aes_sub_bytes_seq.sv | 106 ++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: S-box tables, lookup helpers, engine state enum.
// Byte 0 of every table is held in the most significant bits.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [2047:0] SBOX_F = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_I = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    return SBOX_F[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] sbox_i(input logic [7:0] b);
    return SBOX_I[8*(255-int'(b)) +: 8];
  endfunction

  // LSB position of byte i in a wb-byte word, byte 0 at the top
  function automatic int byte_lsb(input int wb, input int i);
    return 8*(wb-1-i);
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane, forward or inverse by mode.
// SBOX_SELF_CHECK_EN adds a round-trip check through the opposite table.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
`ifdef SBOX_SELF_CHECK_EN
  output logic       bad,
`endif
  output logic [7:0] dout
);

  assign dout = inv ? sbox_i(din) : sbox_f(din);

`ifdef SBOX_SELF_CHECK_EN
  logic [7:0] back;
  assign back = inv ? sbox_f(dout) : sbox_i(dout);
  assign bad  = (back != din);
`endif

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Sequential SubBytes/InvSubBytes, LANES bytes per cycle, in place.
// SBOX_SELF_CHECK_EN enables the sticky lane round-trip error flag.
module aes_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int WORD_BYTES = 16,
  parameter int LANES      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_inv,
  input  logic [8*WORD_BYTES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic                    busy,
  output logic                    err
);

  localparam int NSLICE = WORD_BYTES / LANES;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int W      = 8 * WORD_BYTES;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  data;
  logic          mode;
  logic          accept;
  logic          last;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];
`ifdef SBOX_SELF_CHECK_EN
  logic [LANES-1:0] lane_bad;
`endif

  assign in_ready  = (state == IDLE) |
                     ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CW'(NSLICE-1));
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? data : '0;
  assign busy      = (state == BUSY);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] =
      data[byte_lsb(WORD_BYTES, int'(cnt)*LANES + l) +: 8];
    aes_sbox_lane u_lane (
      .din  (lane_in[l]),
      .inv  (mode),
`ifdef SBOX_SELF_CHECK_EN
      .bad  (lane_bad[l]),
`endif
      .dout (lane_out[l])
    );
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = BUSY;
      BUSY: if (last) state_nx = DONE;
      DONE: begin
        if (out_ready)
          state_nx = in_valid ? BUSY : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      data  <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        data <= in_data;
        mode <= in_inv;
        cnt  <= '0;
      end else if (state == BUSY) begin
        for (int l = 0; l < LANES; l++)
          data[byte_lsb(WORD_BYTES, int'(cnt)*LANES + l) +: 8]
            <= lane_out[l];
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  end

`ifdef SBOX_SELF_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if ((state == BUSY) && (|lane_bad))
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Scoreboard bench: default, LANES=16 and WORD_BYTES=4/LANES=1 instances.
module tb_aes_sub_bytes_seq;

  typedef struct {
    int           i;
    logic [127:0] d;
    logic         c;
  } ent_t;

  localparam logic [127:0] VA = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] VB = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   iv, inv, ordy;
  logic [2:0]   irdy, ov, bsy, er;
  logic [127:0] id [2];
  logic [127:0] od [2];
  logic [31:0]  id_b, od_b;

  ent_t q[$];
  int   lq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc [3];
  int   last_pop [3];
  int   ns [3] = '{4, 1, 4};
  int   a0;
  logic [2:0]   pv = 3'b000;
  logic [127:0] mdat;

  aes_sub_bytes_seq u_d0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_inv(inv[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .busy(bsy[0]), .err(er[0])
  );

  aes_sub_bytes_seq #(.WORD_BYTES(16), .LANES(16)) u_d1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_inv(inv[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .busy(bsy[1]), .err(er[1])
  );

  aes_sub_bytes_seq #(.WORD_BYTES(4), .LANES(1)) u_d2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_inv(inv[2]), .in_data(id_b),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od_b), .busy(bsy[2]), .err(er[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] od_of(input int i);
    if (i == 0) return od[0];
    if (i == 1) return od[1];
    return {96'b0, od_b};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mdat = od_of(i);
      chk("in_ready", 128'(irdy[i]),
          128'((!bsy[i] && !ov[i]) || (ov[i] && ordy[i])));
      if (ov[i]) begin
        if (q.size() == 0 || q[0].i != i) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out inst=%0d act=%h", i, mdat);
        end else begin
          if (q[0].c) chk("out_data", mdat, q[0].d);
          if (!pv[i] && lq.size() > 0) begin
            chk("latency", 128'(cyc - lq[0]), 128'(ns[i]));
            void'(lq.pop_front());
          end
          if (ordy[i]) begin
            void'(q.pop_front());
            last_pop[i] = cyc + 1;
          end
        end
      end
      pv[i] = ov[i];
    end
  end

  task automatic send(input int i, input logic [127:0] d,
                      input logic m, input logic [127:0] e,
                      input logic c);
    int t = 0;
    iv[i]  = 1'b1;
    inv[i] = m;
    if (i < 2) id[i] = d;
    else id_b = d[31:0];
    @(negedge clk);
    while (!irdy[i] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!irdy[i]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst=%0d act=0 exp=1", i);
      iv[i] = 1'b0;
      return;
    end
    q.push_back('{i, e, c});
    lq.push_back(cyc + 1);
    last_acc[i] = cyc + 1;
    @(posedge clk);
    #1;
    iv[i]  = 1'b0;
    inv[i] = ~m;
    if (i < 2) id[i] = {$urandom, $urandom, $urandom, $urandom};
    else id_b = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout act=%0d exp=0", q.size());
      q.delete();
      lq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    iv    = '0;
    inv   = '0;
    ordy  = 3'b111;
    id[0] = '0;
    id[1] = '0;
    id_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(ov), 128'(0));
    chk("rst_out_data0", od[0], '0);
    chk("rst_out_data1", od[1], '0);
    chk("rst_out_data2", 128'(od_b), '0);
    chk("rst_busy", 128'(bsy), 128'(0));
    chk("rst_err", 128'(er), 128'(0));
    chk("rst_in_ready", 128'(irdy), 128'(3'b111));
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(0, VA, 1'b0, VB, 1'b1);
    drain();
    send(0, VB, 1'b1, VA, 1'b1);
    drain();

    send(0, VA, 1'b0, VB, 1'b1);
    a0 = last_acc[0];
    send(0, VB, 1'b1, VA, 1'b1);
    chk("throughput0", 128'(last_acc[0] - a0), 128'(5));
    drain();

    ordy[0] = 1'b0;
    send(0, VA, 1'b0, VB, 1'b1);
    for (int t = 0; t < 20 && !ov[0]; t++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("bp_in_ready", 128'(irdy[0]), 128'(0));
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    send(0, VB, 1'b1, VA, 1'b1);
    chk("bp_same_cycle", 128'(last_acc[0]), 128'(last_pop[0]));
    drain();

    send(0, VA, 1'b0, VB, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(ov[0]), 128'(0));
    chk("midrst_out_data", od[0], '0);
    chk("midrst_busy", 128'(bsy[0]), 128'(0));
    q.delete();
    lq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("postrst_in_ready", 128'(irdy[0]), 128'(1));
    send(0, VB, 1'b1, VA, 1'b1);
    drain();

    send(1, VA, 1'b0, VB, 1'b1);
    drain();
    send(1, VB, 1'b1, VA, 1'b1);
    drain();
    send(1, VA, 1'b0, VB, 1'b1);
    a0 = last_acc[1];
    send(1, VB, 1'b1, VA, 1'b1);
    chk("throughput1", 128'(last_acc[1] - a0), 128'(2));
    drain();

    send(2, 128'h005363ff, 1'b0, 128'h63edfb16, 1'b1);
    drain();
    send(2, 128'h6300ed7d, 1'b1, 128'h00525313, 1'b1);
    drain();

    for (int n = 0; n < 1000; n++)
      send(1, {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)), '0, 1'b0);
    drain();
    chk("err_final", 128'(er), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
